// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the fetch/data memory port arbiter.
// Holds the state encoding, grant type, starvation bounds and latched command.
package mem_port_arbiter_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_BUSY_I = 2'd1;
  localparam logic [1:0] ST_BUSY_D = 2'd2;
  localparam logic [1:0] ST_RESP   = 2'd3;

  typedef enum logic {GNT_I = 1'b0, GNT_D = 1'b1} gnt_e;

  localparam int MAX_D_RUN_MIN = 1;
  localparam int MAX_D_RUN_MAX = 15;
  localparam int RUN_CNT_W     = 4;

  typedef struct packed {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
  } mem_cmd_t;

  // Data wins unless a fetch is waiting and the data run has hit its limit.
  function automatic gnt_e pick_grant(input logic if_req, input logic d_req,
                                      input logic run_at_max);
    return (d_req && !(if_req && run_at_max)) ? GNT_D : GNT_I;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Pipeline-side and memory-side signals of the arbiter as one bundle.
// slave is the arbiter's view; master is the pipeline/memory environment's view.
interface mem_port_arbiter_if;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_done;
  logic        d_req;
  logic        d_wr;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [31:0] d_rdata;
  logic        d_done;
  logic        mem_req;
  logic        mem_wr;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic        stall;

  modport slave (
    input  if_req, if_addr, d_req, d_wr, d_addr, d_wdata, mem_ready, mem_rdata,
    output if_rdata, if_done, d_rdata, d_done, mem_req, mem_wr, mem_addr, mem_wdata, stall
  );

  modport master (
    output if_req, if_addr, d_req, d_wr, d_addr, d_wdata, mem_ready, mem_rdata,
    input  if_rdata, if_done, d_rdata, d_done, mem_req, mem_wr, mem_addr, mem_wdata, stall
  );
endinterface

// File: rtl/mem_port_arbiter_starve_counter.sv
// Counts consecutive data grants taken while a fetch waits; saturates at the limit.
// at_max is a registered compare, so it reflects grants up to the previous cycle.
module mem_port_arbiter_starve_counter
  import mem_port_arbiter_pkg::*;
#(
  parameter int MAX_D_RUN = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic inc,
  output logic at_max
);

  // Out-of-range limits are clamped so the counter width always suffices.
  localparam int LIMIT = (MAX_D_RUN < MAX_D_RUN_MIN) ? MAX_D_RUN_MIN :
                         (MAX_D_RUN > MAX_D_RUN_MAX) ? MAX_D_RUN_MAX : MAX_D_RUN;
  localparam logic [RUN_CNT_W-1:0] LIMIT_V = RUN_CNT_W'(LIMIT);

  logic [RUN_CNT_W-1:0] run_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      run_cnt <= '0;
    end else if (clr) begin
      run_cnt <= '0;
    end else if (inc && (run_cnt != LIMIT_V)) begin
      run_cnt <= run_cnt + RUN_CNT_W'(1);
    end
  end

  assign at_max = (run_cnt == LIMIT_V);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one variable-latency memory port between fetch and data; req-to-done >= 2 cycles.
// Data has priority with bounded fetch starvation; stall holds the pipeline while any access is pending.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int MAX_D_RUN = 4
) (
  input logic              clk,
  input logic              reset,
  mem_port_arbiter_if.slave bus
);

  logic [1:0] state;
  mem_cmd_t   cmd;
  gnt_e       gnt;
  logic       grant_fire;
  logic       run_at_max;
  logic       cnt_inc;
  logic       cnt_clr;

  assign gnt        = pick_grant(bus.if_req, bus.d_req, run_at_max);
  assign grant_fire = (state == ST_IDLE) && (bus.if_req || bus.d_req);
  // Only a data grant that bypasses a waiting fetch extends the run.
  assign cnt_inc    = grant_fire && (gnt == GNT_D) && bus.if_req;
  assign cnt_clr    = grant_fire && !((gnt == GNT_D) && bus.if_req);

  mem_port_arbiter_starve_counter #(
    .MAX_D_RUN (MAX_D_RUN)
  ) u_starve_counter (
    .clk    (clk),
    .reset  (reset),
    .clr    (cnt_clr),
    .inc    (cnt_inc),
    .at_max (run_at_max)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= ST_IDLE;
      cmd          <= '0;
      bus.mem_req  <= 1'b0;
      bus.if_done  <= 1'b0;
      bus.d_done   <= 1'b0;
      bus.if_rdata <= '0;
      bus.d_rdata  <= '0;
    end else begin
      bus.if_done <= 1'b0;
      bus.d_done  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (grant_fire) begin
            bus.mem_req <= 1'b1;
            if (gnt == GNT_D) begin
              state <= ST_BUSY_D;
              cmd   <= '{wr: bus.d_wr, addr: bus.d_addr, wdata: bus.d_wdata};
            end else begin
              state <= ST_BUSY_I;
              cmd   <= '{wr: 1'b0, addr: bus.if_addr, wdata: 32'd0};
            end
          end
        end
        ST_BUSY_I, ST_BUSY_D: begin
          if (bus.mem_ready) begin
            bus.mem_req <= 1'b0;
            state       <= ST_RESP;
            if (state == ST_BUSY_D) begin
              bus.d_rdata <= bus.mem_rdata;
              bus.d_done  <= 1'b1;
            end else begin
              bus.if_rdata <= bus.mem_rdata;
              bus.if_done  <= 1'b1;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.mem_wr    = cmd.wr;
  assign bus.mem_addr  = cmd.addr;
  assign bus.mem_wdata = cmd.wdata;
  assign bus.stall     = (bus.if_req & ~bus.if_done) | (bus.d_req & ~bus.d_done);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a transaction-level reference model and
// a programmable wait-state memory responder.
module tb_mem_port_arbiter;

  localparam int MAXD = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mem_port_arbiter_if bus();

  mem_port_arbiter #(.MAX_D_RUN(MAXD)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- memory responder ----------------
  int mem_wait = 0;
  bit spur = 1'b0;
  int wcnt = 0;
  bit prev_req = 1'b0;

  function automatic logic [31:0] memval(input logic [31:0] a);
    return (a == 32'h40) ? 32'h2001_0005 : (a ^ 32'hC0DE_0000);
  endfunction

  initial begin
    bus.mem_ready = 1'b0;
    bus.mem_rdata = 32'h5A5A_5A5A;
    forever begin
      @(posedge clk);
      #2;
      if (bus.mem_req) begin
        wcnt = prev_req ? wcnt + 1 : 0;
        bus.mem_ready = (wcnt == mem_wait);
        bus.mem_rdata = bus.mem_ready ? memval(bus.mem_addr) : 32'h5A5A_5A5A;
      end else begin
        bus.mem_ready = spur;
        bus.mem_rdata = 32'h5A5A_5A5A;
      end
      prev_req = bus.mem_req;
    end
  end

  // ---------------- reference model + per-cycle compare ----------------
  bit          m_active, m_answered, m_is_d, m_wr, m_if_done, m_d_done;
  logic [31:0] m_addr, m_wdata, m_if_rdata, m_d_rdata;
  int          m_run;
  int          n_if_done = 0;
  int          mreq_cnt = 0;

  always @(negedge clk) begin
    if (reset) begin
      m_active = 0; m_answered = 0; m_is_d = 0; m_wr = 0; m_if_done = 0; m_d_done = 0;
      m_addr = 0; m_wdata = 0; m_if_rdata = 0; m_d_rdata = 0; m_run = 0;
      chk("rst_mem_req", 32'(bus.mem_req), 32'd0);
      chk("rst_if_done", 32'(bus.if_done), 32'd0);
      chk("rst_d_done", 32'(bus.d_done), 32'd0);
      chk("rst_if_rdata", bus.if_rdata, 32'd0);
      chk("rst_d_rdata", bus.d_rdata, 32'd0);
    end else begin
      chk("mem_req", 32'(bus.mem_req), 32'(m_active && !m_answered));
      if (m_active && !m_answered) begin
        chk("mem_wr", 32'(bus.mem_wr), 32'(m_wr));
        chk("mem_addr", bus.mem_addr, m_addr);
        chk("mem_wdata", bus.mem_wdata, m_wdata);
      end
      chk("if_done", 32'(bus.if_done), 32'(m_if_done));
      chk("d_done", 32'(bus.d_done), 32'(m_d_done));
      chk("if_rdata", bus.if_rdata, m_if_rdata);
      chk("d_rdata", bus.d_rdata, m_d_rdata);
      chk("stall", 32'(bus.stall),
          32'((bus.if_req && !m_if_done) || (bus.d_req && !m_d_done)));
      chk("one_done", 32'(bus.if_done & bus.d_done), 32'd0);
      if (bus.if_done) n_if_done++;
      if (bus.mem_req) mreq_cnt++;

      // A transaction is: grant, memory phase until ready, one response cycle.
      m_if_done = 0;
      m_d_done  = 0;
      if (!m_active) begin
        if (bus.d_req && !(bus.if_req && m_run == MAXD)) begin
          m_active = 1; m_answered = 0; m_is_d = 1;
          m_wr = bus.d_wr; m_addr = bus.d_addr; m_wdata = bus.d_wdata;
          m_run = bus.if_req ? ((m_run < MAXD) ? m_run + 1 : MAXD) : 0;
        end else if (bus.if_req) begin
          m_active = 1; m_answered = 0; m_is_d = 0;
          m_wr = 0; m_addr = bus.if_addr; m_wdata = 0;
          m_run = 0;
        end
      end else if (!m_answered) begin
        if (bus.mem_ready) begin
          m_answered = 1;
          if (m_is_d) begin m_d_rdata = bus.mem_rdata; m_d_done = 1; end
          else begin m_if_rdata = bus.mem_rdata; m_if_done = 1; end
        end
      end else begin
        m_active = 0;
      end
    end
  end

  // ---------------- requester drivers ----------------
  int f_req_cyc, f_done_cyc, d_req_cyc, d_done_cyc, d_gap, d_before_f;
  bit f_seen = 1'b1;

  task automatic fetch(input logic [31:0] a);
    bit got;
    got = 0;
    @(posedge clk); #1;
    bus.if_addr = a; bus.if_req = 1'b1; f_req_cyc = cyc; f_seen = 0;
    for (int i = 0; i < 100 && !got; i++) begin
      @(posedge clk); #1;
      if (bus.if_done) got = 1;
    end
    if (got) begin
      f_done_cyc = cyc; f_seen = 1;
    end else begin
      vectors++; miscompares++;
      $display("FAIL fetch_timeout: no if_done for addr %h", a);
    end
    @(posedge clk); #1;
    bus.if_req = 1'b0;
  endtask

  // n back-to-back accesses; req stays high and address advances after each done.
  task automatic data(input int n, input logic wr, input logic [31:0] a, input logic [31:0] wd);
    bit got;
    @(posedge clk); #1;
    bus.d_wr = wr; bus.d_addr = a; bus.d_wdata = wd; bus.d_req = 1'b1;
    d_req_cyc = cyc; d_before_f = 0;
    for (int k = 0; k < n; k++) begin
      got = 0;
      for (int i = 0; i < 100 && !got; i++) begin
        @(posedge clk); #1;
        if (bus.d_done) got = 1;
      end
      if (!got) begin
        vectors++; miscompares++;
        $display("FAIL data_timeout: no d_done for access %0d", k);
        break;
      end
      if (k == 0) d_done_cyc = cyc;
      if (k == 1) d_gap = cyc - d_done_cyc;
      if (!f_seen) d_before_f++;
      @(posedge clk); #1;
      bus.d_addr = a + 32'((k + 1) * 4);
      bus.d_wdata = wd + 32'(k + 1);
    end
    bus.d_req = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  int base, rel, rdone;
  bit got;

  initial begin
    reset = 1'b1;
    bus.if_req = 0; bus.if_addr = 0;
    bus.d_req = 0; bus.d_wr = 0; bus.d_addr = 0; bus.d_wdata = 0;
    @(posedge clk); #1;
    chk("init_mem_req", 32'(bus.mem_req), 32'd0);
    chk("init_mem_addr", bus.mem_addr, 32'd0);
    chk("init_stall", 32'(bus.stall), 32'd0);
    @(posedge clk); #3;
    reset = 1'b0;
    repeat (2) @(posedge clk);

    // single zero-wait fetch
    mem_wait = 0;
    fetch(32'h40);
    chk("fetch_latency", 32'(f_done_cyc - f_req_cyc), 32'd2);
    chk("fetch_rdata", bus.if_rdata, 32'h2001_0005);

    // store with three wait states
    mem_wait = 3;
    mreq_cnt = 0;
    data(1, 1'b1, 32'h100, 32'hDEAD_BEEF);
    chk("store_latency", 32'(d_done_cyc - d_req_cyc), 32'd5);
    chk("store_mreq_cycles", 32'(mreq_cnt), 32'd4);
    chk("store_rdata_capture", bus.d_rdata, 32'hC0DE_0100);

    // simultaneous requests with an empty run: data first
    mem_wait = 0;
    fork
      fetch(32'h80);
      data(1, 1'b0, 32'h104, 32'h0);
    join
    chk("prio_d_latency", 32'(d_done_cyc - d_req_cyc), 32'd2);
    chk("prio_fetch_after", 32'(f_done_cyc - d_done_cyc), 32'd3);

    // continuous data stream against a waiting fetch
    fork
      fetch(32'h200);
      data(6, 1'b0, 32'h300, 32'h0);
    join
    chk("starve_d_grants", 32'(d_before_f), 32'd4);
    chk("b2b_spacing", 32'(d_gap), 32'd3);
    chk("starve_fetch_rdata", bus.if_rdata, 32'hC0DE_0200);

    // async reset in the middle of a long store
    mem_wait = 10;
    @(posedge clk); #1;
    bus.d_wr = 1; bus.d_addr = 32'h500; bus.d_wdata = 32'h1234_5678; bus.d_req = 1;
    repeat (3) @(posedge clk);
    #3 reset = 1'b1;
    #1;
    chk("arst_mem_req", 32'(bus.mem_req), 32'd0);
    chk("arst_mem_wr", 32'(bus.mem_wr), 32'd0);
    chk("arst_mem_addr", bus.mem_addr, 32'd0);
    chk("arst_mem_wdata", bus.mem_wdata, 32'd0);
    chk("arst_d_rdata", bus.d_rdata, 32'd0);
    chk("arst_if_rdata", bus.if_rdata, 32'd0);
    chk("arst_stall", 32'(bus.stall), 32'd1);
    @(posedge clk); #3;
    reset = 1'b0; mem_wait = 0; rel = cyc;
    got = 0;
    for (int i = 0; i < 50 && !got; i++) begin
      @(posedge clk); #1;
      if (bus.d_done) begin got = 1; rdone = cyc; end
    end
    if (!got) begin
      vectors++; miscompares++;
      $display("FAIL resume_timeout: no d_done after reset release");
    end else begin
      chk("resume_latency", 32'(rdone - rel), 32'd2);
    end
    @(posedge clk); #1;
    bus.d_req = 0;

    // spurious mem_ready while idle and in the response cycle
    mem_wait = 1;
    spur = 1;
    base = n_if_done;
    repeat (3) @(posedge clk);
    #1;
    chk("spur_idle_hold", bus.if_rdata, 32'h0);
    fetch(32'h44);
    chk("spur_fetch_latency", 32'(f_done_cyc - f_req_cyc), 32'd3);
    repeat (3) @(posedge clk);
    #1;
    spur = 0;
    chk("spur_done_count", 32'(n_if_done - base), 32'd1);
    chk("spur_rdata", bus.if_rdata, 32'hC0DE_0044);
    repeat (2) @(posedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Sequential arbiter that lets the pipelined CPU's instruction-fetch stage and MEM stage share one single-ported, variable-latency memory. Sits between the pipeline and the memory: latches the winning request, runs a req/ready transaction to memory, returns read data with a one-cycle done pulse, and drives a stall that freezes the pipeline registers and PC while any access is outstanding. Data accesses have priority; a bounded-starvation counter guarantees fetch progress.

## Interface
- MAX_D_RUN, 4: consecutive data grants allowed while a fetch waits; range 1..15
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- if_req  in  1  fetch request; held until if_done
- if_addr  in  32  fetch address (PC); stable while if_req
- if_rdata  out  32  fetched instruction; valid when if_done
- if_done  out  1  one-cycle fetch-complete pulse
- d_req  in  1  data request; held until d_done
- d_wr  in  1  1 = store, 0 = load; stable while d_req
- d_addr  in  32  data address
- d_wdata  in  32  store data (already size-filtered)
- d_rdata  out  32  load data; valid when d_done
- d_done  out  1  one-cycle data-complete pulse
- mem_req  out  1  memory transaction active
- mem_wr  out  1  write strobe, qualified by mem_req
- mem_addr  out  32  memory address
- mem_wdata  out  32  memory write data
- mem_ready  in  1  memory completes transaction this cycle
- mem_rdata  in  32  memory read data; valid with mem_ready
- stall  out  1  freeze pipeline registers and PC

## Operation
- States: IDLE, BUSY_I, BUSY_D, RESP.
- IDLE: no reqs → stay. Otherwise grant: data if d_req and not (if_req and run_cnt == MAX_D_RUN); else fetch. Latch addr/wr/wdata of winner (fetch: mem_wr=0, mem_wdata=0); go BUSY_I/BUSY_D.
- BUSY_x: mem_req=1, latched mem_addr/mem_wr/mem_wdata held constant. mem_ready=0 → stay. mem_ready=1 → capture mem_rdata into if_rdata or d_rdata (stores capture too; value don't-care to requester), go RESP.
- RESP: assert if_done or d_done for the served port; req inputs ignored; next state IDLE unconditionally.
- run_cnt: on data grant with if_req high → saturating increment; on data grant with if_req low → 0; on fetch grant → 0.
- stall = (if_req & ~if_done) | (d_req & ~d_done), combinational.
- if_rdata/d_rdata hold last captured value until next capture for that port.
- Requesters drop or change req only in the cycle after their done; an unchanged req re-requests.
- Reset (async, any state): state=IDLE, mem_req=0, mem_wr=0, mem_addr=0, mem_wdata=0, if_done=0, d_done=0, if_rdata=0, d_rdata=0, run_cnt=0. In-flight memory transaction abandoned; memory must accept mem_req dropping without ready.

## Timing
- Req seen in IDLE at cycle t → mem_req from t+1 → mem_ready at cycle k ≥ t+1 → done at k+1 → IDLE at k+2.
- Minimum req-to-done latency 2 cycles; back-to-back throughput one access per 3 cycles with zero-wait memory.
- mem_ready while not BUSY ignored.
- Simultaneous if_req and d_req in IDLE: data wins unless run_cnt == MAX_D_RUN.
- Requests rising during BUSY/RESP wait; no preemption.
- done pulses exactly one cycle; never both dones in one cycle.
- All outputs except stall registered.

## Structure
- Shared package: state encoding (2-bit IDLE=0, BUSY_I=1, BUSY_D=2, RESP=3), grant enum (GNT_I, GNT_D), MAX_D_RUN bounds.
- One natural sub-module: starve_counter (saturating run_cnt with clear/increment, compare to MAX_D_RUN). Everything else inline in one FSM.

## Test plan
- Single fetch, addr 0x40, mem_ready 1 cycle after mem_req, rdata 0x20010005 → if_done at t+2, if_rdata=0x20010005, mem_wr=0, stall high t..t+1 only.
- Store d_addr 0x100, d_wdata 0xDEADBEEF, 3 wait states → mem_addr/mem_wdata/mem_wr stable for all 4 mem_req cycles; d_done one cycle after mem_ready.
- if_req and d_req together in IDLE, run_cnt=0 → data served first, fetch next; if_done 3 cycles after d_done.
- MAX_D_RUN=4, d_req held with a new access after each d_done, if_req constant → exactly 4 data grants, then fetch grant, run_cnt→0.
- Reset asserted mid-BUSY_D with mem_ready low → all outputs zero asynchronously, state IDLE; after release with d_req high, fresh transaction starts, no stale done.
- Spurious mem_ready in IDLE and RESP → no state change, no capture, no done.
